// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates a fetch port and a data port onto one
// single-port memory. Data requests normally win over fetch. A transaction
// lasts from the grant edge until the first cycle with m_ready=1, and the
// arbiter then spends at least one cycle in IDLE before the next grant.
// Optional feature: define ARB_STARVE_GUARD_EN to add a 2-bit streak counter.
// After three data grants in a row made while fetch was waiting, fetch is
// served ahead of data.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic        m_ready,
  input  logic [15:0] m_rdata,
  output logic        stall_if,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        grant_if_s;
  logic        grant_d_s;
  logic        m_en_r;
  logic        m_we_r;
  logic [15:0] m_addr_r;
  logic [15:0] m_wdata_r;
  logic [15:0] if_rdata_r;
  logic [15:0] d_rdata_r;
  logic        err_r;
  logic        if_done_s;
  logic        d_done_s;

`ifdef ARB_STARVE_GUARD_EN
  logic [1:0]  streak_r;
`endif

  // Grant decision, made only while IDLE
  always_comb begin
    grant_if_s = 1'b0;
    grant_d_s  = 1'b0;
    if (state_r == IDLE) begin
`ifdef ARB_STARVE_GUARD_EN
      if (if_req && (streak_r == 2'd3)) begin
        grant_if_s = 1'b1;
      end else if (d_rd || d_wr) begin
        grant_d_s = 1'b1;
      end else if (if_req) begin
        grant_if_s = 1'b1;
      end else begin
        grant_if_s = 1'b0;
      end
`else
      if (d_rd || d_wr) begin
        grant_d_s = 1'b1;
      end else if (if_req) begin
        grant_if_s = 1'b1;
      end else begin
        grant_if_s = 1'b0;
      end
`endif
    end else begin
      grant_if_s = 1'b0;
      grant_d_s  = 1'b0;
    end
  end

  // Next-state logic: grant out of IDLE, return to IDLE on completion
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          state_next_s = BUSY_D;
        end else if (grant_if_s) begin
          state_next_s = BUSY_IF;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (m_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Completion strobes; gated by reset so an abandoned transaction never acks
  always_comb begin
    if_done_s = rst_n && (state_r == BUSY_IF) && m_ready;
    d_done_s  = rst_n && (state_r == BUSY_D) && m_ready;
  end

  // State, command and read-data registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      m_en_r     <= 1'b0;
      m_we_r     <= 1'b0;
      m_addr_r   <= 16'h0000;
      m_wdata_r  <= 16'h0000;
      if_rdata_r <= 16'h0000;
      d_rdata_r  <= 16'h0000;
      err_r      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      m_en_r  <= (state_next_s != IDLE);
      if (grant_d_s) begin
        m_addr_r  <= d_addr;
        m_wdata_r <= d_wdata;
        m_we_r    <= d_wr;
      end else if (grant_if_s) begin
        m_addr_r <= if_addr;
        m_we_r   <= 1'b0;
      end
      if (grant_d_s && d_rd && d_wr) begin
        err_r <= 1'b1;
      end
      if (if_done_s) begin
        if_rdata_r <= m_rdata;
      end
      if (d_done_s) begin
        d_rdata_r <= m_rdata;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  // Streak of data grants made while fetch was waiting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_r <= 2'd0;
    end else if (grant_if_s) begin
      streak_r <= 2'd0;
    end else if (grant_d_s) begin
      if (if_req) begin
        streak_r <= streak_r + 2'd1;
      end else begin
        streak_r <= 2'd0;
      end
    end
  end
`endif

  // Output drive: acks and read-data bypass are combinational with m_ready
  always_comb begin
    m_en     = m_en_r;
    m_we     = m_we_r;
    m_addr   = m_addr_r;
    m_wdata  = m_wdata_r;
    err      = err_r;
    if_ack   = if_done_s;
    d_ack    = d_done_s;
    if_rdata = if_done_s ? m_rdata : if_rdata_r;
    d_rdata  = d_done_s ? m_rdata : d_rdata_r;
    stall_if = if_req && !((state_r == BUSY_IF) && m_ready);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model is
// compared on every falling edge, plus directed scenarios with literal values.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, if_req, d_rd, d_wr, m_ready;
  logic [15:0] if_addr, d_addr, d_wdata, m_rdata;
  logic        if_ack, d_ack, m_en, m_we, stall_if, err;
  logic [15:0] if_rdata, d_rdata, m_addr, m_wdata;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;
  byte ack_q[$];

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // model state: one outstanding transaction at most
  bit          mbusy, mown_d, mwe, merr;
  logic [15:0] maddr, mwdata, mif_last, md_last;
  int          mstreak;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata), .d_rd(d_rd), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .stall_if(stall_if), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // transaction model updated on each rising edge
  always @(posedge clk) begin
    if (!rst_n) begin
      mbusy <= 1'b0; mown_d <= 1'b0; mwe <= 1'b0; merr <= 1'b0;
      maddr <= 16'h0; mwdata <= 16'h0; mif_last <= 16'h0; md_last <= 16'h0;
      mstreak <= 0;
    end else if (!mbusy) begin
      if (if_req && (!(d_rd || d_wr) || (GUARD && mstreak == 3))) begin
        mbusy <= 1'b1; mown_d <= 1'b0; maddr <= if_addr; mwe <= 1'b0;
        mstreak <= 0;
      end else if (d_rd || d_wr) begin
        mbusy <= 1'b1; mown_d <= 1'b1; maddr <= d_addr; mwdata <= d_wdata;
        mwe <= d_wr;
        if (d_rd && d_wr) merr <= 1'b1;
        mstreak <= if_req ? mstreak + 1 : 0;
      end
    end else if (m_ready) begin
      mbusy <= 1'b0;
      if (mown_d) md_last <= m_rdata;
      else        mif_last <= m_rdata;
    end
  end

  // compare DUT against model on every falling edge; log ack order
  always @(negedge clk) begin
    if (chk_on) begin
      logic e_if, e_d;
      e_if = rst_n && mbusy && !mown_d && m_ready;
      e_d  = rst_n && mbusy &&  mown_d && m_ready;
      chk("m_en", {31'd0, m_en}, {31'd0, mbusy});
      chk("if_ack", {31'd0, if_ack}, {31'd0, e_if});
      chk("d_ack", {31'd0, d_ack}, {31'd0, e_d});
      chk("if_rdata", {16'd0, if_rdata}, {16'd0, e_if ? m_rdata : mif_last});
      chk("d_rdata", {16'd0, d_rdata}, {16'd0, e_d ? m_rdata : md_last});
      chk("stall_if", {31'd0, stall_if},
          {31'd0, if_req && !(mbusy && !mown_d && m_ready)});
      chk("err", {31'd0, err}, {31'd0, merr});
      if (mbusy) begin
        chk("m_addr", {16'd0, m_addr}, {16'd0, maddr});
        chk("m_we", {31'd0, m_we}, {31'd0, mwe});
        if (mwe) chk("m_wdata", {16'd0, m_wdata}, {16'd0, mwdata});
      end
      if (d_ack === 1'b1) ack_q.push_back(8'h44);
      if (if_ack === 1'b1) ack_q.push_back(8'h49);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drop_all();
    if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
  endtask

  // wait (bounded) for the selected ack at a falling edge
  task automatic wait_ack(input bit want_d, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((want_d ? d_ack : if_ack) === 1'b1) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      total++; bad++;
      $display("FAIL ack_timeout want_d=%0d actual=none required=ack", want_d);
    end
  endtask

  initial begin
    int c;
    int en_cnt, ack_cnt, gstart;
    byte exp_pat[5];
    rst_n = 1'b0; drop_all(); m_ready = 1'b0;
    if_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0; m_rdata = 16'h0;

    // reset for two cycles
    step(); chk_on = 1'b1;
    step();
    @(negedge clk);
    chk("rst_m_en", {31'd0, m_en}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_m_addr", {16'd0, m_addr}, 32'h0);
    chk("rst_if_rdata", {16'd0, if_rdata}, 32'h0);

    // fetch after reset, memory always ready
    step();
    rst_n = 1'b1; if_req = 1'b1; if_addr = 16'h0010; m_ready = 1'b1; m_rdata = 16'h1234;
    wait_ack(1'b0, c);
    chk("fetch_m_en", {31'd0, m_en}, 32'd1);
    chk("fetch_m_addr", {16'd0, m_addr}, 32'h0010);
    chk("fetch_rdata", {16'd0, if_rdata}, 32'h1234);
    step(); drop_all(); m_rdata = 16'h5555;
    step(); step();
    chk("fetch_rdata_hold", {16'd0, if_rdata}, 32'h1234);

    // simultaneous fetch and data read: data first
    if_req = 1'b1; if_addr = 16'h0002; d_rd = 1'b1; d_addr = 16'h0100; m_rdata = 16'hA5A5;
    wait_ack(1'b1, c);
    chk("sim_stall", {31'd0, stall_if}, 32'd1);
    chk("sim_d_rdata", {16'd0, d_rdata}, 32'hA5A5);
    chk("sim_d_addr", {16'd0, m_addr}, 32'h0100);
    step(); d_rd = 1'b0; m_rdata = 16'h0F0F;
    wait_ack(1'b0, c);
    chk("sim_gap", c, 32'd2);
    chk("sim_if_addr", {16'd0, m_addr}, 32'h0002);
    chk("sim_if_rdata", {16'd0, if_rdata}, 32'h0F0F);
    step(); drop_all(); step(); step();

    // write with three wait states
    d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'hBEEF; m_ready = 1'b0;
    step();
    en_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) m_ready = 1'b1;
      @(negedge clk);
      en_cnt += int'(m_en); ack_cnt += int'(d_ack);
      if (i == 3) begin
        chk("ws_m_we", {31'd0, m_we}, 32'd1);
        chk("ws_m_wdata", {16'd0, m_wdata}, 32'hBEEF);
        chk("ws_m_addr", {16'd0, m_addr}, 32'h0200);
      end
      if (i < 3) step();
    end
    chk("ws_en_cycles", en_cnt, 32'd4);
    chk("ws_ack_count", ack_cnt, 32'd1);
    step(); drop_all(); step(); step();

    // read and write together: write issued, sticky error
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0004; d_wdata = 16'h7777;
    wait_ack(1'b1, c);
    chk("perr_m_we", {31'd0, m_we}, 32'd1);
    step(); drop_all(); step(); step(); step();
    @(negedge clk);
    chk("perr_sticky", {31'd0, err}, 32'd1);
    step(); rst_n = 1'b0; step(); rst_n = 1'b1;
    @(negedge clk);
    chk("perr_cleared", {31'd0, err}, 32'd0);

    // reset in the middle of a data read
    step();
    d_rd = 1'b1; d_addr = 16'h0300; m_ready = 1'b0;
    step(); step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rmid_no_ack", {31'd0, d_ack}, 32'd0);
    step(); rst_n = 1'b1; d_rd = 1'b0;
    chk("rmid_m_en", {31'd0, m_en}, 32'd0);
    chk("rmid_d_ack", {31'd0, d_ack}, 32'd0);
    step(); step();

    // sustained data reads with fetch waiting
    gstart = ack_q.size();
    m_ready = 1'b1; d_rd = 1'b1; d_addr = 16'h0400; if_req = 1'b1; if_addr = 16'h0040;
    for (int i = 0; i < 12; i++) step();
    drop_all(); step(); step(); step();
`ifdef ARB_STARVE_GUARD_EN
    exp_pat = '{8'h44, 8'h44, 8'h44, 8'h49, 8'h44};
`else
    exp_pat = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h44};
`endif
    chk("starve_len_ok", {31'd0, ack_q.size() >= gstart + 5}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (ack_q.size() > gstart + i)
        chk($sformatf("starve_grant%0d", i), {24'd0, ack_q[gstart + i]}, {24'd0, exp_pat[i]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
